// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the sequence detector.
// It has a one-word holding buffer so consecutive frames stream back-to-back.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_valid,
  input  logic [WIDTH-1:0]           load_data,
  output logic                       load_ready,
  output logic                       data,
  output logic                       bit_valid,
  output logic                       frame_done,
  output logic                       busy,
  output logic [$clog2(WIDTH)-1:0]   bit_idx
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] PEN_IDX  = IDX_W'(WIDTH - 2);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] buffer;
  logic             buf_full;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign load_ready = ~buf_full;

  // data holds the bit currently emitted; sr holds the bits still to come
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      buffer     <= '0;
      buf_full   <= 1'b0;
      data       <= IDLE_BIT;
      bit_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      bit_idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            state      <= SHIFT;
            data       <= first_bit(load_data);
            sr         <= shift_out(load_data);
            bit_valid  <= 1'b1;
            frame_done <= 1'b0;
            busy       <= 1'b1;
            bit_idx    <= '0;
          end
        end
        SHIFT: begin
          if (bit_idx != LAST_IDX) begin
            data       <= first_bit(sr);
            sr         <= shift_out(sr);
            bit_idx    <= bit_idx + IDX_W'(1);
            frame_done <= (bit_idx == PEN_IDX);
            if (load_valid && !buf_full) begin
              buffer   <= load_data;
              buf_full <= 1'b1;
            end
          end else if (buf_full) begin
            data       <= first_bit(buffer);
            sr         <= shift_out(buffer);
            buf_full   <= 1'b0;
            bit_idx    <= '0;
            frame_done <= 1'b0;
          end else if (load_valid) begin
            data       <= first_bit(load_data);
            sr         <= shift_out(load_data);
            bit_idx    <= '0;
            frame_done <= 1'b0;
          end else begin
            state      <= IDLE;
            data       <= IDLE_BIT;
            bit_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            bit_idx    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: MSB-first instance for most vectors,
// a second LSB-first instance for the bit-order vector.
module tb_serial_bit_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_ready, data, bit_valid, frame_done, busy;
  logic [2:0] bit_idx;

  logic       l_valid = 1'b0;
  logic [7:0] l_data = 8'h00;
  logic       l_ready, l_out, l_bv, l_fd, l_busy;
  logic [2:0] l_idx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .data(data), .bit_valid(bit_valid),
    .frame_done(frame_done), .busy(busy), .bit_idx(bit_idx));

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(l_valid), .load_data(l_data),
    .load_ready(l_ready), .data(l_out), .bit_valid(l_bv),
    .frame_done(l_fd), .busy(l_busy), .bit_idx(l_idx));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, " data"}, 32'(data), 32'd0);
    check_val({tag, " bit_valid"}, 32'(bit_valid), 32'd0);
    check_val({tag, " busy"}, 32'(busy), 32'd0);
    check_val({tag, " load_ready"}, 32'(load_ready), 32'd1);
  endtask

  // emission-order expected streams, written out by hand
  logic [0:7]  exp_d0   = 8'b1101_0000;
  logic [0:15] exp_pair = 16'b1101_0000_0000_1101;
  logic [0:7]  exp_55   = 8'b0101_0101;
  logic [0:7]  exp_aa   = 8'b1010_1010;
  logic [0:7]  exp_ff   = 8'b1111_1111;
  logic [0:7]  exp_lsb  = 8'b1101_0000;

  initial begin
    #1 rst = 1'b1;
    #2;
    check_val("rst data", 32'(data), 32'd0);
    check_val("rst bit_valid", 32'(bit_valid), 32'd0);
    check_val("rst frame_done", 32'(frame_done), 32'd0);
    check_val("rst busy", 32'(busy), 32'd0);
    check_val("rst bit_idx", 32'(bit_idx), 32'd0);
    step();
    step();
    #2 rst = 1'b0;
    step();
    check_idle("post_rst");

    // single word 0xD0
    load_valid = 1'b1; load_data = 8'hD0;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("w1 data[%0d]", i), 32'(data), 32'(exp_d0[i]));
      check_val($sformatf("w1 bv[%0d]", i), 32'(bit_valid), 32'd1);
      check_val($sformatf("w1 fd[%0d]", i), 32'(frame_done), 32'(i == 7));
      check_val($sformatf("w1 idx[%0d]", i), 32'(bit_idx), 32'(i));
      if (i < 7) step();
    end
    step();
    check_idle("w1_end");

    // 0xD0 then 0x0D back-to-back through the buffer
    load_valid = 1'b1; load_data = 8'hD0;
    step();
    for (int i = 0; i < 16; i++) begin
      check_val($sformatf("w2 data[%0d]", i), 32'(data), 32'(exp_pair[i]));
      check_val($sformatf("w2 bv[%0d]", i), 32'(bit_valid), 32'd1);
      check_val($sformatf("w2 fd[%0d]", i), 32'(frame_done), 32'(i == 7 || i == 15));
      check_val($sformatf("w2 idx[%0d]", i), 32'(bit_idx), 32'(i % 8));
      check_val($sformatf("w2 ready[%0d]", i), 32'(load_ready), 32'(!(i >= 1 && i <= 7)));
      check_val($sformatf("w2 busy[%0d]", i), 32'(busy), 32'd1);
      if (i == 0) load_data = 8'h0D;
      if (i == 1) load_valid = 1'b0;
      if (i < 15) step();
    end
    step();
    check_idle("w2_end");

    // 0xAA offered exactly on the end-of-frame edge of 0x55
    load_valid = 1'b1; load_data = 8'h55;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("w3a data[%0d]", i), 32'(data), 32'(exp_55[i]));
      if (i == 7) begin
        check_val("w3a fd", 32'(frame_done), 32'd1);
        load_valid = 1'b1; load_data = 8'hAA;
      end
      step();
    end
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("w3b data[%0d]", i), 32'(data), 32'(exp_aa[i]));
      check_val($sformatf("w3b bv[%0d]", i), 32'(bit_valid), 32'd1);
      check_val($sformatf("w3b idx[%0d]", i), 32'(bit_idx), 32'(i));
      check_val($sformatf("w3b ready[%0d]", i), 32'(load_ready), 32'd1);
      if (i < 7) step();
    end
    step();
    check_idle("w3_end");

    // 0xFF aborted by async reset after its 3rd bit, with 0xF0 buffered
    load_valid = 1'b1; load_data = 8'hFF;
    step();
    load_data = 8'hF0;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("w4 data[%0d]", i), 32'(data), 32'(exp_ff[i]));
      if (i == 1) begin
        check_val("w4 ready_buffered", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
      end
      if (i < 2) step();
    end
    #2 rst = 1'b1;
    #1;
    check_val("w4 rst data", 32'(data), 32'd0);
    check_val("w4 rst bv", 32'(bit_valid), 32'd0);
    check_val("w4 rst busy", 32'(busy), 32'd0);
    check_val("w4 rst fd", 32'(frame_done), 32'd0);
    check_val("w4 rst idx", 32'(bit_idx), 32'd0);
    #2 rst = 1'b0;
    step();
    check_idle("w4_after");
    load_valid = 1'b1; load_data = 8'h80;
    step();
    load_valid = 1'b0;
    check_val("w4 new idx0", 32'(bit_idx), 32'd0);
    check_val("w4 new data0", 32'(data), 32'd1);
    step();
    check_val("w4 new idx1", 32'(bit_idx), 32'd1);
    check_val("w4 new data1", 32'(data), 32'd0);
    for (int i = 2; i < 8; i++) step();
    check_val("w4 new fd", 32'(frame_done), 32'd1);
    step();
    check_idle("w4_end");

    // LSB-first instance, word 8'b00001011
    l_valid = 1'b1; l_data = 8'b0000_1011;
    step();
    l_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check_val($sformatf("lsb data[%0d]", i), 32'(l_out), 32'(exp_lsb[i]));
      check_val($sformatf("lsb idx[%0d]", i), 32'(l_idx), 32'(i));
      check_val($sformatf("lsb fd[%0d]", i), 32'(l_fd), 32'(i == 7));
      if (i < 7) step();
    end
    step();
    check_val("lsb end bv", 32'(l_bv), 32'd0);
    check_val("lsb end busy", 32'(l_busy), 32'd0);
    check_val("lsb end ready", 32'(l_ready), 32'd1);

    // idle with load_valid low
    for (int i = 0; i < 10; i++) begin
      step();
      check_idle($sformatf("idle[%0d]", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
